// File: rtl/cnt_sched_pkg.sv
// Shared types and defaults for the counter scheduler and its arbiter.
// Optional feature macro: CNT_SCHED_FIXED_PRIO_EN (fixed-priority arbitration).
package cnt_sched_pkg;

  localparam int unsigned DEF_NUM_REQ = 4;
  localparam int unsigned DEF_CNT_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } sched_state_t;

  // Index width for an n-entry requester vector; at least one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cnt_sched_rr_arb.sv
// Combinational arbiter: request vector + start pointer -> one-hot grant and index.
// With CNT_SCHED_FIXED_PRIO_EN defined the search always starts at requester 0.
module rr_arb
  import cnt_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ
) (
  input  logic [NUM_REQ-1:0]          req,
  input  logic [idx_w(NUM_REQ)-1:0]   ptr,
  output logic [NUM_REQ-1:0]          gnt,
  output logic [idx_w(NUM_REQ)-1:0]   idx,
  output logic                        any
);

  localparam int unsigned IW = idx_w(NUM_REQ);

  logic [IW-1:0] start;
  logic [IW-1:0] cand;

  // Walk upward from the start position with explicit wrap; first hit wins.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    any   = 1'b0;
    start = ptr;
`ifdef CNT_SCHED_FIXED_PRIO_EN
    start = '0;
`else
`endif
    cand = start;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!any && req[cand]) begin
        any       = 1'b1;
        idx       = cand;
        gnt[cand] = 1'b1;
      end
      cand = (cand == IW'(NUM_REQ - 1)) ? '0 : cand + IW'(1);
    end
  end

endmodule

// File: rtl/cnt_sched.sv
// Shares one external loadable down-counter among NUM_REQ requesters.
// Arbitration mode selected by CNT_SCHED_FIXED_PRIO_EN (round-robin when undefined).
module cnt_sched
  import cnt_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned CNT_W   = DEF_CNT_W
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [NUM_REQ*CNT_W-1:0]   in_data,
  output logic [NUM_REQ-1:0]         grant_o,
  output logic [NUM_REQ-1:0]         done_o,
  output logic                       busy_o,
  output logic                       cnt_load_o,
  output logic                       cnt_enable_o,
  output logic [CNT_W-1:0]           cnt_data_o,
  input  logic [CNT_W-1:0]           cnt_value_i
);

  localparam int unsigned IW = idx_w(NUM_REQ);

  sched_state_t         state_q, state_d;
  logic [IW-1:0]        owner_q, owner_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [IW-1:0]        owner_next;
  logic [IW-1:0]        arb_idx;
  logic [NUM_REQ-1:0]   arb_gnt;
  logic                 arb_any;
  logic                 owner_req;
  logic [NUM_REQ-1:0]   onehot_d;
  logic [NUM_REQ-1:0]   grant_d;
  logic [NUM_REQ-1:0]   done_d;
  logic [CNT_W-1:0]     slot [NUM_REQ];

  rr_arb #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req (req_i),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_slot
    assign slot[k] = in_data[k*CNT_W +: CNT_W];
  end

  assign owner_req  = req_i[owner_q];
  assign owner_next = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + IW'(1);

  // Load value only during LOAD; in_data is not looked at otherwise.
  assign cnt_data_o = cnt_load_o ? slot[owner_q] : '0;

  // Combinational so the counter is never decremented at zero or after abandon.
  assign cnt_enable_o = (state_q == RUN) && owner_req && (cnt_value_i != '0);

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          owner_d = arb_idx;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (!owner_req) begin
          state_d = IDLE;
          ptr_d   = owner_next;
        end else begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (!owner_req) begin
          state_d = IDLE;
          ptr_d   = owner_next;
        end else if (cnt_value_i == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        ptr_d   = owner_next;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    onehot_d = NUM_REQ'(1) << owner_d;
    grant_d  = (state_d == IDLE) ? '0 : onehot_d;
    done_d   = (state_d == DONE) ? onehot_d : '0;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      ptr_q      <= '0;
      grant_o    <= '0;
      done_o     <= '0;
      busy_o     <= 1'b0;
      cnt_load_o <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      grant_o    <= grant_d;
      done_o     <= done_d;
      busy_o     <= (state_d != IDLE);
      cnt_load_o <= (state_d == LOAD);
    end
  end

endmodule

// File: tb/tb_cnt_sched.sv
// Self-checking bench for cnt_sched: directed scenarios plus a random phase,
// checked each cycle against an ownership-timeline model with an external counter.
module tb_cnt_sched;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 4;
  localparam int unsigned PW = 2;

  logic             clk_in = 1'b0;
  logic             rst_in;
  logic [N-1:0]     req_i;
  logic [N*W-1:0]   in_data;
  logic [N-1:0]     grant_o;
  logic [N-1:0]     done_o;
  logic             busy_o;
  logic             cnt_load_o;
  logic             cnt_enable_o;
  logic [W-1:0]     cnt_data_o;
  logic [W-1:0]     cnt_value;

  cnt_sched #(.NUM_REQ(N), .CNT_W(W)) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .req_i        (req_i),
    .in_data      (in_data),
    .grant_o      (grant_o),
    .done_o       (done_o),
    .busy_o       (busy_o),
    .cnt_load_o   (cnt_load_o),
    .cnt_enable_o (cnt_enable_o),
    .cnt_data_o   (cnt_data_o),
    .cnt_value_i  (cnt_value)
  );

  always #5 clk_in = ~clk_in;

  // The shared external down-counter.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)            cnt_value <= '0;
    else if (cnt_load_o)   cnt_value <= cnt_data_o;
    else if (cnt_enable_o) cnt_value <= cnt_value - W'(1);
  end

  int checks = 0;
  int errors = 0;

  // Requester side
  bit want [N];
  int val  [N];
  bit auto_drop;

  // Reference model: who owns the counter, since which cycle, with which value
  int cyc;
  bit m_busy;
  int m_own, m_s, m_v, m_ptr;

  // Per-test tallies
  int t0, n_en, n_load, done_rel;
  logic [N-1:0] done_pat;
  int done_cnt [N];
  logic [N-1:0] loads [$];
  logic [N-1:0] exp3 [5];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Winner among asserted requests, searching upward from the pointer with wrap.
  function automatic int pick(input logic [N-1:0] r, input int p);
    int start;
    int c;
    start = p;
`ifdef CNT_SCHED_FIXED_PRIO_EN
    start = 0;
`else
`endif
    for (int i = 0; i < N; i++) begin
      c = (start + i) % N;
      if (r[PW'(c)]) return c;
    end
    return 0;
  endfunction

  task automatic apply();
    for (int k = 0; k < N; k++) begin
      req_i[k] = want[k];
      in_data[k*W +: W] = W'(val[k]);
    end
  endtask

  task automatic begin_test();
    t0 = cyc; n_en = 0; n_load = 0; done_rel = -1; done_pat = '0;
    loads.delete();
    for (int k = 0; k < N; k++) done_cnt[k] = 0;
  endtask

  // Check one cycle's outputs against the model, then advance to the next cycle.
  task automatic cycle_check();
    int rel;
    logic [N-1:0] eg, ed;
    logic el, ee;
    logic [W-1:0] edat;
    #1;
    rel = 0; eg = '0; ed = '0; el = 1'b0; ee = 1'b0; edat = '0;
    if (m_busy) begin
      rel = cyc - m_s;
      if (rel == 0) m_v = val[m_own];
      eg   = N'(1) << m_own;
      el   = (rel == 0);
      edat = (rel == 0) ? W'(val[m_own]) : '0;
      ee   = req_i[PW'(m_own)] && rel >= 1 && rel <= m_v;
      ed   = (rel == m_v + 2) ? eg : '0;
    end
    chk("grant",  32'(grant_o),      32'(eg));
    chk("done",   32'(done_o),       32'(ed));
    chk("busy",   32'(busy_o),       32'(m_busy));
    chk("load",   32'(cnt_load_o),   32'(el));
    chk("data",   32'(cnt_data_o),   32'(edat));
    chk("enable", 32'(cnt_enable_o), 32'(ee));
    chk("cnt_not_f", 32'(cnt_value == 4'hF), 32'(0));
    if (cnt_enable_o) n_en++;
    if (cnt_load_o) begin n_load++; loads.push_back(grant_o); end
    if (done_o != '0) begin
      if (done_rel < 0) begin done_rel = cyc - t0; done_pat = done_o; end
      for (int k = 0; k < N; k++) if (done_o[k]) done_cnt[k]++;
    end
    if (m_busy) begin
      if ((rel <= m_v + 1 && !req_i[PW'(m_own)]) || rel == m_v + 2) begin
        m_busy = 1'b0;
        m_ptr  = (m_own + 1) % N;
      end
    end else if (req_i != '0) begin
      m_own  = pick(req_i, m_ptr);
      m_busy = 1'b1;
      m_s    = cyc + 1;
    end
    if (auto_drop) for (int k = 0; k < N; k++) if (ed[k]) want[k] = 1'b0;
    @(negedge clk_in);
    cyc++;
  endtask

  task automatic run(input int n);
    repeat (n) begin apply(); cycle_check(); end
  endtask

  initial begin
    int total;
    rst_in = 1'b1;
    for (int k = 0; k < N; k++) begin want[k] = 1'b0; val[k] = 0; end
    apply();
    auto_drop = 1'b1;
    cyc = 0; m_busy = 1'b0; m_ptr = 0; m_own = 0; m_s = 0; m_v = 0;
`ifdef CNT_SCHED_FIXED_PRIO_EN
    exp3[0] = 4'b0001; exp3[1] = 4'b0001; exp3[2] = 4'b0001; exp3[3] = 4'b0001; exp3[4] = 4'b0001;
`else
    exp3[0] = 4'b0001; exp3[1] = 4'b0010; exp3[2] = 4'b0100; exp3[3] = 4'b1000; exp3[4] = 4'b0001;
`endif

    // Reset values
    #1;
    chk("rst_grant",  32'(grant_o),      32'(0));
    chk("rst_done",   32'(done_o),       32'(0));
    chk("rst_busy",   32'(busy_o),       32'(0));
    chk("rst_load",   32'(cnt_load_o),   32'(0));
    chk("rst_enable", 32'(cnt_enable_o), 32'(0));
    chk("rst_data",   32'(cnt_data_o),   32'(0));
    @(negedge clk_in);
    rst_in = 1'b0;

    // Single requester 0 with value 3
    begin_test();
    want[0] = 1'b1; val[0] = 3;
    run(9);
    chk("t1_load_cycles", 32'(n_load),   32'(1));
    chk("t1_en_cycles",   32'(n_en),     32'(3));
    chk("t1_done_cycle",  32'(done_rel), 32'(6));
    chk("t1_done_pat",    32'(done_pat), 32'(4'b0001));
    chk("t1_grant_idle",  32'(grant_o),  32'(0));

    // Reset asserted mid-RUN at value 2
    begin_test();
    want[1] = 1'b1; val[1] = 2;
    run(2);
    apply();
    #1;
    chk("t2_value_before_rst", 32'(cnt_value), 32'(2));
    #1;
    rst_in = 1'b1;
    #1;
    chk("t2_rst_grant",  32'(grant_o),      32'(0));
    chk("t2_rst_enable", 32'(cnt_enable_o), 32'(0));
    chk("t2_rst_busy",   32'(busy_o),       32'(0));
    chk("t2_rst_done",   32'(done_o),       32'(0));
    want[1] = 1'b0;
    apply();
    @(negedge clk_in);
    rst_in = 1'b0;
    cyc++;
    m_busy = 1'b0; m_ptr = 0;
    chk("t2_no_done", 32'(done_cnt[1]), 32'(0));

    // All four requesting with value 1, held continuously
    begin_test();
    auto_drop = 1'b0;
    for (int k = 0; k < N; k++) begin want[k] = 1'b1; val[k] = 1; end
    run(26);
    chk("t3_load_count", 32'(loads.size() >= 5), 32'(1));
    for (int k = 0; k < 5; k++)
      if (k < loads.size()) chk("t3_grant_order", 32'(loads[k]), 32'(exp3[k]));
    total = 0;
    for (int k = 0; k < N; k++) total += done_cnt[k];
    chk("t3_done_total", 32'(total), 32'(5));
    auto_drop = 1'b1;
    for (int k = 0; k < N; k++) want[k] = 1'b0;
    run(4);

    // Zero load value on requester 2
    begin_test();
    want[2] = 1'b1; val[2] = 0;
    run(6);
    chk("t4_en_cycles",  32'(n_en),     32'(0));
    chk("t4_done_cycle", 32'(done_rel), 32'(3));
    chk("t4_done_pat",   32'(done_pat), 32'(4'b0100));

    // Requester 1 abandons in RUN at value 5 while requester 2 waits
    begin_test();
    want[1] = 1'b1; val[1] = 5;
    want[2] = 1'b1; val[2] = 1;
    run(2);
    want[1] = 1'b0;
    apply();
    #1;
    chk("t5_value_at_drop", 32'(cnt_value),    32'(5));
    chk("t5_enable_low",    32'(cnt_enable_o), 32'(0));
    cycle_check();
    run(8);
    chk("t5_load_count", 32'(loads.size()), 32'(2));
    if (loads.size() >= 2) begin
      chk("t5_first_owner", 32'(loads[0]), 32'(4'b0010));
      chk("t5_next_owner",  32'(loads[1]), 32'(4'b0100));
    end
    chk("t5_no_done_1", 32'(done_cnt[1]), 32'(0));
    chk("t5_done_2",    32'(done_cnt[2]), 32'(1));

    // Random traffic with occasional abandonment
    begin_test();
    repeat (400) begin
      for (int k = 0; k < N; k++)
        if (!want[k] && $urandom_range(0, 3) == 0) begin
          want[k] = 1'b1;
          val[k]  = int'($urandom_range(0, 6));
        end
      if (m_busy && $urandom_range(0, 19) == 0) want[m_own] = 1'b0;
      apply();
      cycle_check();
    end
    total = 0;
    for (int k = 0; k < N; k++) total += done_cnt[k];
    chk("rand_progress", 32'(total > 10), 32'(1));
    for (int k = 0; k < N; k++) want[k] = 1'b0;
    run(10);

`ifdef CNT_SCHED_FIXED_PRIO_EN
    // Fixed priority: 1010 held, requester 3 starves
    begin_test();
    auto_drop = 1'b0;
    want[1] = 1'b1; val[1] = 1;
    want[3] = 1'b1; val[3] = 1;
    run(30);
    chk("fp_load_count", 32'(loads.size() >= 5), 32'(1));
    foreach (loads[i]) chk("fp_owner", 32'(loads[i]), 32'(4'b0010));
    chk("fp_starved", 32'(done_cnt[3]), 32'(0));
`else
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cnt_sched.md
Name: cnt_sched

Overview:
- Round-robin scheduler that shares one loadable 4-bit down-counter (load/enable/data in, count out) among NUM_REQ requesters.
- Each requester supplies a timeout value. The scheduler grants one requester, loads its value, and enables decrement until zero.
- It then pulses that requester's done and moves on to the next.
- Sits between requester logic and the single shared counter instance. The counter itself is external.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- CNT_W, 4, counter width; must match the shared counter.

Ports:
- clk_in  input  1  clock, all state updates on rising edge.
- rst_in  input  1  asynchronous, active-high reset.
- req_i  input  NUM_REQ  per-requester request level; held high until done_o or abandoned.
- in_data  input  NUM_REQ*CNT_W  per-requester load value, requester k at bits [k*CNT_W +: CNT_W].
- grant_o  output  NUM_REQ  one-hot owner of the counter; zero when idle.
- done_o  output  NUM_REQ  one-cycle pulse to the owner when its count reaches zero.
- busy_o  output  1  high whenever state != IDLE.
- cnt_load_o  output  1  load strobe to the counter.
- cnt_enable_o  output  1  decrement enable to the counter.
- cnt_data_o  output  CNT_W  load value to the counter.
- cnt_value_i  input  CNT_W  current counter value (count_o of the counter).

Behaviour:
- Reset, asynchronous:
  - State IDLE, rr pointer = 0, grant index = 0.
  - grant_o, done_o, cnt_load_o, cnt_enable_o, cnt_data_o all 0; busy_o = 0.
  - Reset mid-operation abandons the current owner; no done_o is issued.
- States: IDLE, LOAD, RUN, DONE.
- IDLE:
  - If any req_i is high, select a winner round-robin, starting at the rr pointer and searching upward with wrap.
  - Register its index; next state LOAD. Otherwise stay in IDLE.
- LOAD (1 cycle):
  - cnt_load_o = 1, cnt_data_o = in_data slice of the owner, grant_o one-hot. Next state RUN.
- RUN:
  - cnt_enable_o = 1 while cnt_value_i != 0. This is combinational, so enable is never high while the value is 0 and the counter never wraps 0 -> max.
  - When cnt_value_i == 0, next state is DONE.
  - A loaded value of 0 goes to DONE after one RUN cycle with enable low.
- DONE (1 cycle):
  - done_o[owner] = 1.
  - rr pointer = owner + 1, wrapping modulo NUM_REQ. Next state IDLE.
- Abandon: if req_i[owner] drops in LOAD or RUN:
  - Next state IDLE, enable deasserted in that same cycle.
  - No done_o; rr pointer still advances past the owner.
- Latency: with V the loaded value and req_i sampled high in IDLE at edge 0, done_o is high in cycle V+3. Ownership is held for V+3 cycles.
- Back-to-back requests: one idle cycle occurs between owners, because DONE -> IDLE -> LOAD.
- Requests arriving while busy wait; in_data is sampled only during LOAD.
- Width rules: cnt_data_o passes through unchanged at CNT_W; the pointer is $clog2(NUM_REQ) bits with explicit wrap.

Optional Feature:
- Macro: CNT_SCHED_FIXED_PRIO_EN.
- Defined: fixed priority; the lowest-index asserted req_i always wins in IDLE and the rr pointer is unused.
- Undefined: the round-robin selection described above.

Decomposition:
- Package cnt_sched_pkg holds:
  - the sched_state_t enum (IDLE, LOAD, RUN, DONE);
  - default constants for NUM_REQ and CNT_W.
- Sub-module rr_arb:
  - combinational request vector + pointer -> one-hot grant and index;
  - the fixed-priority variant is selected under the macro.
- The FSM stays in cnt_sched.

Test Plan:
- Reset asserted mid-RUN (value 2) -> within the same cycle: grant_o = 0, cnt_enable_o = 0, busy_o = 0; no done_o; next request is served from requester 0.
- req_i = 0001, in_data[0] = 3 -> cnt_load_o high for one cycle with cnt_data_o = 3; enable high for exactly 3 cycles; done_o = 0001 in cycle 6; grant_o returns to 0.
- req_i = 1111, all values 1 -> grants in order 0, 1, 2, 3, 0; each done_o pulses once per ownership; one idle cycle between owners.
- in_data[2] = 0, only req 2 high -> LOAD, one RUN cycle with cnt_enable_o = 0, done_o = 0100 in cycle 3; counter never reads F.
- req_i[1] dropped during RUN at value 5 -> enable low in that cycle; no done_o; next grant goes to requester 2 when pending.
- With CNT_SCHED_FIXED_PRIO_EN defined, req_i = 1010 held continuously -> requester 1 is granted every time and requester 3 is starved.
